// File: rtl/led_game_pkg.sv
// ============================================================================
// led_game_pkg : shared types, digit codes and helpers for led_count_game
// Revision     : 1.0
// ============================================================================
`default_nettype none

package led_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // 7-segment digit codes understood by the board's display driver
    localparam logic [3:0] DIG_O     = 4'h0;
    localparam logic [3:0] DIG_G     = 4'h9;
    localparam logic [3:0] DIG_N     = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hB;
    localparam logic [3:0] DIG_D     = 4'hC;
    localparam logic [3:0] DIG_U     = 4'hD;
    localparam logic [3:0] DIG_P     = 4'hE;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Two-digit BCD of a value 0..99, tens digit in the upper nibble
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v % 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// ============================================================================
// lfsr16   : free-running 16-bit Fibonacci LFSR, taps 16,15,13,4
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/led_count_game.sv
// ============================================================================
// led_count_game : bouncing LED sweep, stop it on a random target count
// Revision       : 1.0
// ============================================================================
`default_nettype none

module led_count_game
    import led_game_pkg::*;
#(
    parameter int          N_LEDS    = 16,
    parameter int          TICK_DIV  = 100_000_000,
    parameter int          MAX_TRIES = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              btn,
    input  logic              dot_mode,
    output logic [N_LEDS-1:0] led,
    output logic [15:0]       seg_data,
    output logic              win,
    output logic              lose,
    output logic [3:0]        tries_left
);

    localparam int             PW     = $clog2(N_LEDS + 1);
    localparam int             TW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  P_MAX  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]  N_VAL  = PW'(N_LEDS);
    localparam logic [TW-1:0]  TC_MAX = TW'(TICK_DIV - 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     p_q, p_d;
    logic              dir_q, dir_d;
    logic [TW-1:0]     tc_q, tc_d;
    logic [PW-1:0]     target_q, target_d;
    logic [3:0]        tries_q, tries_d;
    logic              hold_first_q, hold_first_d;
    logic              btn_prev_q, btn_prev_d;

    logic [N_LEDS-1:0] led_q, led_d;
    logic [15:0]       seg_q, seg_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [3:0]        tries_out_q, tries_out_d;

    logic [15:0]       lfsr_w;
    logic              btn_edge;
    logic              tick;
    logic [PW-1:0]     count;
    logic [PW-1:0]     tgt_pos;
    logic [7:0]        count_bcd;
    logic [7:0]        tgt_bcd;
    logic [7:0]        hint;
    logic [N_LEDS-1:0] bar_pat;
    logic [N_LEDS-1:0] dot_pat;
    logic [N_LEDS-1:0] tgt_pat;
    logic [N_LEDS-1:0] run_pat;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr    (lfsr_w)
    );

    assign btn_edge  = btn & ~btn_prev_q;
    assign tick      = (tc_q == TC_MAX);
    assign count     = N_VAL - p_q;
    assign tgt_pos   = N_VAL - target_q;
    assign count_bcd = to_bcd(7'(count));
    assign tgt_bcd   = to_bcd(7'(target_q));

    always_comb begin
        bar_pat = '0;
        dot_pat = '0;
        tgt_pat = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            bar_pat[i] = (PW'(i) >= p_q);
            dot_pat[i] = (PW'(i) == p_q);
            tgt_pat[i] = (PW'(i) >= tgt_pos);
        end
        run_pat = dot_mode ? dot_pat : bar_pat;
    end

    always_comb begin
        hint = {DIG_DASH, DIG_DASH};
        if (count < target_q) begin
            hint = {DIG_U, DIG_P};
        end else if (count > target_q) begin
            hint = {DIG_D, DIG_N};
        end
    end

    // Game state, position sweep and attempt bookkeeping
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        dir_d        = dir_q;
        tc_d         = tc_q;
        target_d     = target_q;
        tries_d      = tries_q;
        hold_first_d = 1'b0;
        btn_prev_d   = btn;

        case (state_q)
            ST_IDLE: begin
                target_d = PW'(lfsr_w % 16'(N_LEDS)) + PW'(1);
                tries_d  = 4'(MAX_TRIES);
                p_d      = P_MAX;
                dir_d    = DIR_DOWN;
                tc_d     = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (btn_edge) begin
                    state_d      = ST_HOLD;
                    tries_d      = tries_q - 4'd1;
                    tc_d         = '0;
                    hold_first_d = 1'b1;
                end else if (tick) begin
                    tc_d = '0;
                    if (dir_q == DIR_DOWN) begin
                        if (p_q == '0) begin
                            dir_d = DIR_UP;
                            p_d   = p_q + PW'(1);
                        end else begin
                            p_d = p_q - PW'(1);
                        end
                    end else begin
                        if (p_q == P_MAX) begin
                            dir_d = DIR_DOWN;
                            p_d   = p_q - PW'(1);
                        end else begin
                            p_d = p_q + PW'(1);
                        end
                    end
                end else begin
                    tc_d = tc_q + TW'(1);
                end
            end
            ST_HOLD: begin
                // The first HOLD cycle only decides win/lose; a press there is dropped
                if (count == target_q) begin
                    state_d = ST_WIN;
                end else if (tries_q == 4'd0) begin
                    state_d = ST_LOSE;
                end else if (btn_edge && !hold_first_q) begin
                    state_d = ST_RUN;
                    tc_d    = '0;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (btn_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!active) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs are a registered view of the current state/position
    always_comb begin
        led_d       = run_pat;
        seg_d       = {DIG_BLANK, DIG_BLANK, tgt_bcd};
        win_d       = 1'b0;
        lose_d      = 1'b0;
        tries_out_d = tries_q;

        case (state_q)
            ST_HOLD: begin
                seg_d = {count_bcd, hint};
            end
            ST_WIN: begin
                led_d = '1;
                seg_d = {DIG_G, DIG_O, DIG_O, DIG_D};
                win_d = 1'b1;
            end
            ST_LOSE: begin
                led_d  = tgt_pat;
                seg_d  = {DIG_DASH, DIG_DASH, tgt_bcd};
                lose_d = 1'b1;
            end
            default: begin
                led_d = run_pat;
            end
        endcase

        if (!active) begin
            led_d       = '0;
            seg_d       = {4{DIG_BLANK}};
            win_d       = 1'b0;
            lose_d      = 1'b0;
            tries_out_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            p_q          <= P_MAX;
            dir_q        <= DIR_DOWN;
            tc_q         <= '0;
            target_q     <= PW'(1);
            tries_q      <= 4'd0;
            hold_first_q <= 1'b0;
            btn_prev_q   <= 1'b0;
            led_q        <= '0;
            seg_q        <= 16'hFFFF;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            tries_out_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            dir_q        <= dir_d;
            tc_q         <= tc_d;
            target_q     <= target_d;
            tries_q      <= tries_d;
            hold_first_q <= hold_first_d;
            btn_prev_q   <= btn_prev_d;
            led_q        <= led_d;
            seg_q        <= seg_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            tries_out_q  <= tries_out_d;
        end
    end

    assign led        = led_q;
    assign seg_data   = seg_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign tries_left = tries_out_q;

endmodule

`default_nettype wire

// File: tb/tb_led_count_game.sv
// ============================================================================
// tb_led_count_game : directed self-checking bench for led_count_game
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_led_count_game;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: 16 LEDs, 4-cycle step, 3 tries
    logic        a_reset_n = 1'b0;
    logic        a_active  = 1'b0;
    logic        a_btn     = 1'b0;
    logic        a_dot     = 1'b0;
    logic [15:0] a_led;
    logic [15:0] a_seg;
    logic        a_win;
    logic        a_lose;
    logic [3:0]  a_tries;

    // DUT B: 4 LEDs, 2-cycle step, 1 try
    logic        b_reset_n = 1'b0;
    logic        b_active  = 1'b0;
    logic        b_btn     = 1'b0;
    logic        b_dot     = 1'b0;
    logic [3:0]  b_led;
    logic [15:0] b_seg;
    logic        b_win;
    logic        b_lose;
    logic [3:0]  b_tries;

    led_count_game #(
        .N_LEDS    (16),
        .TICK_DIV  (4),
        .MAX_TRIES (3),
        .LFSR_SEED (16'hACE1)
    ) u_dut_a (
        .clk        (clk),
        .reset_n    (a_reset_n),
        .active     (a_active),
        .btn        (a_btn),
        .dot_mode   (a_dot),
        .led        (a_led),
        .seg_data   (a_seg),
        .win        (a_win),
        .lose       (a_lose),
        .tries_left (a_tries)
    );

    led_count_game #(
        .N_LEDS    (4),
        .TICK_DIV  (2),
        .MAX_TRIES (1),
        .LFSR_SEED (16'h1234)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (b_reset_n),
        .active     (b_active),
        .btn        (b_btn),
        .dot_mode   (b_dot),
        .led        (b_led),
        .seg_data   (b_seg),
        .win        (b_win),
        .lose       (b_lose),
        .tries_left (b_tries)
    );

    // Reference LFSRs, used only to predict the drawn target
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    logic [15:0] m_a;
    logic [15:0] m_b;
    always @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) m_a <= 16'hACE1;
        else            m_a <= lfsr_step(m_a);
    end
    always @(posedge clk or negedge b_reset_n) begin
        if (!b_reset_n) m_b <= 16'h1234;
        else            m_b <= lfsr_step(m_b);
    end

    function automatic logic [7:0] bcd8(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [7:0] hint_code(input int c, input int t);
        if (c < t) return 8'hDE;
        if (c > t) return 8'hCA;
        return 8'hBB;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_a();
        @(negedge clk);
        a_reset_n = 1'b0;
        a_active  = 1'b0;
        a_btn     = 1'b0;
        a_dot     = 1'b0;
        wait_n(2);
        a_reset_n = 1'b1;
        wait_n(1);
    endtask

    task automatic reset_b();
        @(negedge clk);
        b_reset_n = 1'b0;
        b_active  = 1'b0;
        b_btn     = 1'b0;
        b_dot     = 1'b0;
        wait_n(2);
        b_reset_n = 1'b1;
        wait_n(1);
    endtask

    // Leaves the bench on the negedge right after the IDLE->RUN edge
    task automatic start_a(output int t);
        a_active = 1'b1;
        t = int'(m_a) % 16 + 1;
        wait_n(1);
    endtask

    task automatic start_b(output int t);
        b_active = 1'b1;
        t = int'(m_b) % 4 + 1;
        wait_n(1);
    endtask

    task automatic test_reset();
        int t;
        @(negedge clk);
        a_reset_n = 1'b0;
        a_active  = 1'b0;
        a_btn     = 1'b0;
        wait_n(2);
        n_tests++;
        if (a_led !== 16'h0000) begin
            n_fail++; $display("FAIL reset_led: got %h expected 0000", a_led);
        end
        n_tests++;
        if (a_seg !== 16'hFFFF) begin
            n_fail++; $display("FAIL reset_seg: got %h expected FFFF", a_seg);
        end
        n_tests++;
        if ({a_win, a_lose, a_tries} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got win=%b lose=%b tries=%0d expected 0/0/0", a_win, a_lose, a_tries);
        end
        a_reset_n = 1'b1;
        wait_n(1);
        start_a(t);
        wait_n(1);
        n_tests++;
        if (a_led !== 16'h8000) begin
            n_fail++; $display("FAIL start_led: got %h expected 8000", a_led);
        end
        n_tests++;
        if (a_seg !== {8'hFF, bcd8(t)}) begin
            n_fail++; $display("FAIL start_seg: got %h expected %h", a_seg, {8'hFF, bcd8(t)});
        end
        n_tests++;
        if (a_tries !== 4'd3) begin
            n_fail++; $display("FAIL start_tries: got %0d expected 3", a_tries);
        end
    endtask

    task automatic test_miss();
        int t, c, j;
        logic [15:0] e;
        reset_a();
        start_a(t);
        c = (t == 3) ? 2 : 3;
        j = 4 * c - 3;
        wait_n(j - 1);
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        wait_n(1);
        e = 16'hFFFF << (16 - c);
        n_tests++;
        if (a_seg !== {bcd8(c), hint_code(c, t)}) begin
            n_fail++; $display("FAIL miss_seg: got %h expected %h", a_seg, {bcd8(c), hint_code(c, t)});
        end
        n_tests++;
        if (a_tries !== 4'd2) begin
            n_fail++; $display("FAIL miss_tries: got %0d expected 2", a_tries);
        end
        n_tests++;
        if (a_led !== e) begin
            n_fail++; $display("FAIL miss_led: got %h expected %h", a_led, e);
        end
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        wait_n(1);
        n_tests++;
        if (a_led !== e || a_seg[15:8] !== 8'hFF) begin
            n_fail++; $display("FAIL resume_same_p: got led=%h seg=%h expected led=%h seg=FF..", a_led, a_seg, e);
        end
        wait_n(4);
        e = 16'hFFFF << (15 - c);
        n_tests++;
        if (a_led !== e) begin
            n_fail++; $display("FAIL resume_step: got %h expected %h", a_led, e);
        end
    endtask

    task automatic test_tick_edge();
        int t, k, j;
        logic [15:0] e;
        reset_a();
        start_a(t);
        k = (t == 1) ? 2 : 1;
        j = 4 * k;
        wait_n(j - 1);
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        wait_n(1);
        e = 16'hFFFF << (16 - k);
        n_tests++;
        if (a_seg !== {bcd8(k), hint_code(k, t)} || a_led !== e) begin
            n_fail++; $display("FAIL tick_edge: got seg=%h led=%h expected seg=%h led=%h", a_seg, a_led, {bcd8(k), hint_code(k, t)}, e);
        end
    endtask

    task automatic test_win();
        int t, t2, j;
        reset_a();
        start_a(t);
        j = 4 * t - 3;
        wait_n(j - 1);
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        wait_n(1);
        n_tests++;
        if (a_seg !== {bcd8(t), 8'hBB}) begin
            n_fail++; $display("FAIL hit_seg: got %h expected %h", a_seg, {bcd8(t), 8'hBB});
        end
        wait_n(1);
        n_tests++;
        if (a_win !== 1'b1 || a_lose !== 1'b0) begin
            n_fail++; $display("FAIL win_flag: got win=%b lose=%b expected 1/0", a_win, a_lose);
        end
        n_tests++;
        if (a_seg !== 16'h900C || a_led !== 16'hFFFF) begin
            n_fail++; $display("FAIL win_display: got seg=%h led=%h expected 900C/FFFF", a_seg, a_led);
        end
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        t2 = int'(m_a) % 16 + 1;
        wait_n(2);
        n_tests++;
        if (a_win !== 1'b0 || a_seg !== {8'hFF, bcd8(t2)} || a_led !== 16'h8000 || a_tries !== 4'd3) begin
            n_fail++; $display("FAIL new_round: got win=%b seg=%h led=%h tries=%0d expected 0/%h/8000/3",
                               a_win, a_seg, a_led, a_tries, {8'hFF, bcd8(t2)});
        end
    endtask

    task automatic test_active_low();
        int t;
        reset_a();
        start_a(t);
        wait_n(5);
        a_active = 1'b0;
        wait_n(1);
        n_tests++;
        if (a_led !== 16'h0000 || a_seg !== 16'hFFFF) begin
            n_fail++; $display("FAIL active_low: got led=%h seg=%h expected 0000/FFFF", a_led, a_seg);
        end
        wait_n(2);
        n_tests++;
        if (a_led !== 16'h0000 || a_tries !== 4'd0) begin
            n_fail++; $display("FAIL active_low_hold: got led=%h tries=%0d expected 0000/0", a_led, a_tries);
        end
    endtask

    task automatic test_reset_in_hold();
        int t, c, j;
        reset_a();
        start_a(t);
        c = (t == 3) ? 2 : 3;
        j = 4 * c - 3;
        wait_n(j - 1);
        a_btn = 1'b1;
        wait_n(1);
        a_btn = 1'b0;
        wait_n(1);
        #2;
        a_reset_n = 1'b0;
        #1;
        n_tests++;
        if (a_led !== 16'h0000 || a_seg !== 16'hFFFF || a_tries !== 4'd0 || a_win !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_hold: got led=%h seg=%h tries=%0d win=%b expected 0000/FFFF/0/0",
                               a_led, a_seg, a_tries, a_win);
        end
    endtask

    task automatic test_bounce();
        int t;
        logic [3:0] exp_dot [8] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};
        reset_b();
        b_dot = 1'b1;
        start_b(t);
        for (int m = 0; m < 8; m++) begin
            wait_n(1);
            n_tests++;
            if (b_led !== exp_dot[m]) begin
                n_fail++; $display("FAIL bounce_step%0d: got %h expected %h", m, b_led, exp_dot[m]);
            end
            wait_n(1);
        end
        b_dot = 1'b0;
        wait_n(1);
        n_tests++;
        if (b_led !== 4'hE) begin
            n_fail++; $display("FAIL bar_switch: got %h expected e", b_led);
        end
    endtask

    task automatic test_lose();
        int t, c, j;
        logic [3:0] e;
        reset_b();
        start_b(t);
        c = (t == 1) ? 2 : 1;
        j = (c == 1) ? 1 : 3;
        wait_n(j - 1);
        b_btn = 1'b1;
        wait_n(1);
        b_btn = 1'b0;
        wait_n(1);
        n_tests++;
        if (b_seg !== {bcd8(c), hint_code(c, t)} || b_tries !== 4'd0) begin
            n_fail++; $display("FAIL lose_hold: got seg=%h tries=%0d expected %h/0", b_seg, b_tries, {bcd8(c), hint_code(c, t)});
        end
        wait_n(1);
        e = 4'hF;
        e = e << (4 - t);
        n_tests++;
        if (b_lose !== 1'b1 || b_win !== 1'b0) begin
            n_fail++; $display("FAIL lose_flag: got lose=%b win=%b expected 1/0", b_lose, b_win);
        end
        n_tests++;
        if (b_seg !== {8'hBB, bcd8(t)} || b_led !== e) begin
            n_fail++; $display("FAIL lose_display: got seg=%h led=%h expected %h/%h", b_seg, b_led, {8'hBB, bcd8(t)}, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_miss();
        test_tick_edge();
        test_win();
        test_active_low();
        test_reset_in_hold();
        test_bounce();
        test_lose();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_count_game.md
# led_count_game

Parametrised LED-count guessing game: an LED bar or dot sweeps across `N_LEDS` outputs at a programmable step rate. The player stops it with one button and tries to match a pseudo-random target within a limited number of tries. It occupies one mode slot of the board's top-level mode multiplexer, driving the LED bank and the 4-digit 7-segment data bus. It generalises the earlier fixed 16-LED game with:
- configurable width and step rate;
- a bar/dot display mode;
- an attempt limit with a lose state;
- button restart without reset.

## Interface
Parameters:
- `N_LEDS`, 16: number of LEDs; legal range 2..99.
- `TICK_DIV`, 100_000_000: clock cycles per sweep step; minimum 2.
- `MAX_TRIES`, 3: stop attempts per round; legal range 1..9.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports (one clock, `clk`; reset `reset_n` is asynchronous, active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `active` in 1: mode enable; low forces IDLE synchronously.
- `btn` in 1: go/stop button, already synchronised and debounced (level).
- `dot_mode` in 1: 0 = bar display, 1 = single-dot display; sampled every cycle.
- `led` out N_LEDS: LED drive.
- `seg_data` out 16: four 4-bit digit codes, left digit in [15:12].
- `win` out 1: high in WIN.
- `lose` out 1: high in LOSE.
- `tries_left` out 4: remaining attempts.

## Operation
- Digit codes:
  - 0x0–0x9: numerals (0x9 doubles as 'g', 0x0 as 'o').
  - 0xA 'n', 0xB '-', 0xC 'd', 0xD 'U', 0xE 'P', 0xF blank.
- Edge detect: `edge = btn & ~btn_prev`; `btn_prev` is a register.
- LFSR: 16-bit Fibonacci, taps 16,15,13,4. It shifts every cycle in every state.
- Position `p` (0..N_LEDS-1), direction `dir`, tick counter `tc`.
  - `count = N_LEDS - p`, range 1..N_LEDS.
- Pattern:
  - Bar: `led[i] = (i >= p)`.
  - Dot: `led[i] = (i == p)`.
- States:
  - IDLE:
    - Latch `target = (lfsr % N_LEDS) + 1`.
    - Set `tries_left = MAX_TRIES`, `p = N_LEDS-1`, `dir = down`, `tc = 0`.
    - Next state RUN. If `active` is low, stay in IDLE.
  - RUN:
    - `tc` counts 0..TICK_DIV-1. At `TICK_DIV-1`, step `p` and wrap `tc` to 0.
    - Bounce: p = N-1 → 0, then 0 → N-1. Endpoints are reversed, not repeated, e.g. N=4: 3,2,1,0,1,2,3,2…
    - On `edge`: go to HOLD, freeze `p`, decrement `tries_left`.
  - HOLD, evaluated in this priority order:
    1. `count == target` → WIN.
    2. Else if `tries_left == 0` → LOSE.
    3. Else on `edge` → RUN, with `tc = 0` and sweep resuming from the frozen `p`/`dir`.
  - WIN / LOSE: `edge` → IDLE, which starts a new round.
- `active` low in any state: next cycle is IDLE and outputs are cleared.
- Outputs by state:
  - IDLE/RUN: `led` = pattern; `seg_data` = F,F,T1,T0 (target in BCD).
  - HOLD: `led` frozen. `seg_data` = C1,C0,hint, where hint is:
    - U,P if `count < target`;
    - d,n if `count > target`;
    - -,- if `count == target`.
  - WIN: `led` all ones; `seg_data` = 9,0,0,C ("good"); `win` = 1.
  - LOSE: `led` = bar pattern for the target; `seg_data` = B,B,T1,T0; `lose` = 1.

## Timing
- Reset values:
  - `led` = 0, `seg_data` = 16'hFFFF, `win` = 0, `lose` = 0, `tries_left` = 0.
  - State IDLE, LFSR = `LFSR_SEED`, `btn_prev` = 0.
- All outputs are registered, one cycle after the state/position register update.
- The `btn` rising edge is acted on in the cycle after `btn` is sampled high.
- `edge` and tick in the same cycle: `edge` wins and `p` does not advance.
- A HOLD with a miss and tries remaining stays in HOLD at least one cycle.
- `edge` during the HOLD equality/LOSE decision cycle is ignored.
- `reset_n` asserted mid-round clears everything immediately.
- `dot_mode` changes affect only `led` and take effect on the next cycle.
- Widths:
  - `tc`: $clog2(TICK_DIV).
  - `p`, `target`, `count`: $clog2(N_LEDS+1).
  - BCD by constant divide by 10.

## Structure
- Package `led_game_pkg`: state enum (IDLE, RUN, HOLD, WIN, LOSE) and the digit-code localparams.
- Sub-module `lfsr16`: parameter SEED, free-running output.
- Everything else stays in one module.

## Test plan
- Reset/start (N=16, TICK_DIV=4): with `reset_n` low → `led` = 0 and `seg_data` = FFFF. Raise `reset_n` and `active` → within 3 cycles `led` = 16'h8000 and `seg_data[15:8]` = FF.
- Bounce (N=4, TICK_DIV=2): observe 8 steps → `p` sequence 3,2,1,0,1,2,3,2. In dot mode `led` = 8,4,2,1,2,4,8,4.
- Miss: stop at count 3 with target 5 → `seg_data` = 0x03DE, `tries_left` 3→2. The next `edge` resumes RUN at the same `p`.
- Win: stop at count == target → `win` = 1, `seg_data` = 0x900C, `led` all ones. `edge` → IDLE and a new target is drawn.
- Lose (MAX_TRIES=1): a single miss → `lose` = 1, `seg_data` = 0xBB + target BCD, `led` = target bar.
- Corners:
  - `edge` on the tick cycle → `p` unchanged.
  - `active` low mid-RUN → `led` = 0 next cycle.
  - `reset_n` low mid-HOLD → immediate reset values.
